// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 raster reader for frame buffer mem1.
// Walks the read address and realigns sync/enable with BRAM read data.
module vga_frame_reader #(
    parameter int   width      = 640,
    parameter int   height     = 480,
    parameter int   h_fp       = 16,
    parameter int   h_sync     = 96,
    parameter int   h_bp       = 48,
    parameter int   v_fp       = 10,
    parameter int   v_sync     = 2,
    parameter int   v_bp       = 33,
    parameter int   rd_latency = 2,
    parameter logic sync_pol   = 1'b0
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [3:0]  din,
    output logic [18:0] addr_mem1,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        active,
    output logic        frame_start
);

    localparam int H_TOTAL = width + h_fp + h_sync + h_bp;
    localparam int V_TOTAL = height + v_fp + v_sync + v_bp;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT  = HW'(width);
    localparam logic [HW-1:0] H_XL   = HW'(width - 1);
    localparam logic [HW-1:0] H_SS   = HW'(width + h_fp);
    localparam logic [HW-1:0] H_SE   = HW'(width + h_fp + h_sync - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(height);
    localparam logic [VW-1:0] V_YL   = VW'(height - 1);
    localparam logic [VW-1:0] V_SS   = VW'(height + v_fp);
    localparam logic [VW-1:0] V_SE   = VW'(height + v_fp + v_sync - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [18:0]   addr_q, addr_d;

    logic [rd_latency-1:0] act_sr_q, act_sr_d;
    logic [rd_latency-1:0] hs_sr_q, hs_sr_d;
    logic [rd_latency-1:0] vs_sr_q, vs_sr_d;
    logic [rd_latency-1:0] fs_sr_q, fs_sr_d;

    logic [3:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       act_q, act_d;
    logic       fs_q, fs_d;

    logic act0, hs0, vs0, fs0;

    always_comb begin
        act0 = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs0  = (hcnt_q >= H_SS) && (hcnt_q <= H_SE);
        vs0  = (vcnt_q >= V_SS) && (vcnt_q <= V_SE);
        fs0  = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Simultaneous h and v wrap falls out as a frame wrap.
    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    // Address wraps on the last visible pixel, not on the frame wrap.
    always_comb begin
        addr_d = addr_q;
        if (act0) begin
            if ((hcnt_q == H_XL) && (vcnt_q == V_YL))
                addr_d = '0;
            else
                addr_d = addr_q + 19'd1;
        end
    end

    always_comb begin
        act_sr_d    = act_sr_q << 1;
        act_sr_d[0] = act0;
        hs_sr_d     = hs_sr_q << 1;
        hs_sr_d[0]  = hs0;
        vs_sr_d     = vs_sr_q << 1;
        vs_sr_d[0]  = vs0;
        fs_sr_d     = fs_sr_q << 1;
        fs_sr_d[0]  = fs0;
    end

    always_comb begin
        act_d = act_sr_q[rd_latency-1];
        fs_d  = fs_sr_q[rd_latency-1];
        rgb_d = act_d ? din : 4'd0;
        hs_d  = hs_sr_q[rd_latency-1] ? sync_pol : ~sync_pol;
        vs_d  = vs_sr_q[rd_latency-1] ? sync_pol : ~sync_pol;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            addr_q   <= '0;
            act_sr_q <= '0;
            hs_sr_q  <= '0;
            vs_sr_q  <= '0;
            fs_sr_q  <= '0;
            rgb_q    <= '0;
            hs_q     <= ~sync_pol;
            vs_q     <= ~sync_pol;
            act_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            addr_q   <= addr_d;
            act_sr_q <= act_sr_d;
            hs_sr_q  <= hs_sr_d;
            vs_sr_q  <= vs_sr_d;
            fs_sr_q  <= fs_sr_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            act_q    <= act_d;
            fs_q     <= fs_d;
        end
    end

    assign addr_mem1   = addr_q;
    assign vga_r       = rgb_q;
    assign vga_g       = rgb_q;
    assign vga_b       = rgb_q;
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign active      = act_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: small raster, random frame buffer contents,
// random mid-frame resets, positional reference model.
module tb_vga_frame_reader;

    localparam int W   = 16;
    localparam int H   = 6;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int RL  = 2;
    localparam int L   = RL + 1;
    localparam int HT  = W + HFP + HS + HBP;
    localparam int VT  = H + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic        clk25;
    logic        rst_n;
    logic [3:0]  din;
    logic [18:0] addr_mem1;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, active, frame_start;

    logic [3:0]  mem [W*H];
    logic [18:0] a1;

    int n_vec;
    int n_bad;
    int e;

    vga_frame_reader #(
        .width(W), .height(H),
        .h_fp(HFP), .h_sync(HS), .h_bp(HBP),
        .v_fp(VFP), .v_sync(VS), .v_bp(VBP),
        .rd_latency(RL), .sync_pol(1'b0)
    ) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .din(din),
        .addr_mem1(addr_mem1),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .active(active),
        .frame_start(frame_start)
    );

    initial begin
        clk25 = 1'b0;
        forever #20 clk25 = ~clk25;
    end

    // Two-cycle read BRAM model.
    always @(posedge clk25) begin
        a1  <= addr_mem1;
        din <= mem[a1];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s e=%0d got %0h want %0h", tag, e, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int pos);
        int x, y;
        x = pos % HT;
        y = pos / HT;
        if (y >= H) return 0;
        if (x < W) return y * W + x;
        if ((y + 1) * W == W * H) return 0;
        return (y + 1) * W;
    endfunction

    task automatic check_reset();
        chk("rst_addr", 32'(addr_mem1), 0);
        chk("rst_r", 32'(vga_r), 0);
        chk("rst_g", 32'(vga_g), 0);
        chk("rst_b", 32'(vga_b), 0);
        chk("rst_act", 32'(active), 0);
        chk("rst_hs", 32'(vga_hsync), 1);
        chk("rst_vs", 32'(vga_vsync), 1);
        chk("rst_fs", 32'(frame_start), 0);
    endtask

    task automatic check_run();
        int s, p, x, y;
        int ea, ehs, evs, efs, ergb;
        ea   = 0;
        ehs  = 1;
        evs  = 1;
        efs  = 0;
        ergb = 0;
        chk("addr", 32'(addr_mem1), 32'(exp_addr(e % FT)));
        s = e - L;
        if (s >= 0) begin
            p = s % FT;
            x = p % HT;
            y = p / HT;
            ea  = (x < W && y < H) ? 1 : 0;
            ehs = (x >= W + HFP && x < W + HFP + HS) ? 0 : 1;
            evs = (y >= H + VFP && y < H + VFP + VS) ? 0 : 1;
            efs = (p == 0) ? 1 : 0;
            if (ea == 1) ergb = 32'(mem[y * W + x]);
        end
        chk("active", 32'(active), 32'(ea));
        chk("hsync", 32'(vga_hsync), 32'(ehs));
        chk("vsync", 32'(vga_vsync), 32'(evs));
        chk("fstart", 32'(frame_start), 32'(efs));
        chk("r", 32'(vga_r), 32'(ergb));
        chk("g", 32'(vga_g), 32'(ergb));
        chk("b", 32'(vga_b), 32'(ergb));
    endtask

    initial begin
        int k;
        n_vec = 0;
        n_bad = 0;
        e     = 0;
        for (int i = 0; i < W * H; i++) mem[i] = 4'($urandom);
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk25);
            check_reset();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk25);
            e++;
            @(negedge clk25);
            check_run();
            if (c == 700 || $urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                check_reset();
                k = $urandom_range(1, 5);
                repeat (k) begin
                    @(negedge clk25);
                    check_reset();
                end
                rst_n = 1'b1;
                e = 0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
